// File: rtl/pc_sequencer.sv
// Multi-cycle control sequencer: owns the PC and instruction register and
// walks each instruction through FETCH, DECODE, EXEC, MEM and WB.
module pc_sequencer #(
  parameter int unsigned          ADDR_WIDTH = 32,
  parameter int unsigned          INSN_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  halt,
  output logic                  imemReq,
  output logic [ADDR_WIDTH-1:0] imemAddr,
  input  logic                  imemAck,
  input  logic [INSN_WIDTH-1:0] imemData,
  output logic [INSN_WIDTH-1:0] insn,
  input  logic                  isMem,
  input  logic                  isStore,
  input  logic                  wbNeeded,
  output logic                  dmemReq,
  output logic                  dmemWe,
  input  logic                  dmemAck,
  output logic [ADDR_WIDTH-1:0] brPcIn,
  input  logic [ADDR_WIDTH-1:0] brPcOut,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  regWrEn,
  output logic                  retired,
  output logic [2:0]            state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  w_retire;
  logic                  r_retired;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [INSN_WIDTH-1:0] r_insn;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_pc      <= RESET_PC;
      r_insn    <= '0;
      r_retired <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_retired <= w_retire;
      if (r_state == FETCH && imemAck)
        r_insn <= imemData;
      if (r_state == EXEC)
        r_pc <= brPcOut;
    end
  end

  // Every path that ends an instruction also checks halt, so halt only
  // ever parks the core between instructions.
  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    case (r_state)
      IDLE:   if (!halt) w_next = FETCH;
      FETCH:  if (imemAck) w_next = DECODE;
      DECODE: w_next = EXEC;
      EXEC: begin
        if (isMem)
          w_next = MEM;
        else if (wbNeeded)
          w_next = WB;
        else begin
          w_next   = halt ? IDLE : FETCH;
          w_retire = 1'b1;
        end
      end
      MEM: begin
        if (dmemAck) begin
          if (wbNeeded && !isStore)
            w_next = WB;
          else begin
            w_next   = halt ? IDLE : FETCH;
            w_retire = 1'b1;
          end
        end
      end
      WB: begin
        w_next   = halt ? IDLE : FETCH;
        w_retire = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    imemReq = 1'b0;
    dmemReq = 1'b0;
    dmemWe  = 1'b0;
    regWrEn = 1'b0;
    case (r_state)
      FETCH: imemReq = 1'b1;
      MEM: begin
        dmemReq = 1'b1;
        dmemWe  = isStore;
      end
      WB:    regWrEn = 1'b1;
      default: ;
    endcase
  end

  assign imemAddr = r_pc;
  assign brPcIn   = r_pc;
  assign pc       = r_pc;
  assign insn     = r_insn;
  assign retired  = r_retired;
  assign state    = r_state;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multi-cycle control sequencer for the tutorial processor core.
- Owns the architectural PC and the instruction register.
- Drives the instruction/data memory request handshakes and steps the core through FETCH, DECODE, EXEC, MEM and WB.
- Presents the current PC to the branch unit and commits the branch unit's next-PC result once per instruction.

Parameters:
- ADDR_WIDTH, 32, width of PC and memory addresses.
- INSN_WIDTH, 32, width of an instruction word.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- halt  input  1  level; when high, FETCH does not start a new instruction.
- imemReq  output  1  instruction fetch request.
- imemAddr  output  ADDR_WIDTH  fetch address, equals pc.
- imemAck  input  1  fetch data valid this cycle.
- imemData  input  INSN_WIDTH  fetched instruction.
- insn  output  INSN_WIDTH  latched instruction register, to decoder.
- isMem  input  1  decoded: instruction accesses data memory (valid from DECODE onward).
- isStore  input  1  decoded: memory access is a store.
- wbNeeded  input  1  decoded: instruction writes the register file.
- dmemReq  output  1  data memory request.
- dmemWe  output  1  data memory write enable, qualified by dmemReq.
- dmemAck  input  1  data access complete this cycle.
- brPcIn  output  ADDR_WIDTH  current PC to branch unit, equals pc.
- brPcOut  input  ADDR_WIDTH  next PC from branch unit (taken or fall-through).
- pc  output  ADDR_WIDTH  architectural PC.
- regWrEn  output  1  one-cycle register-file write strobe.
- retired  output  1  one-cycle pulse per completed instruction.
- state  output  3  encoded state, for debug.

Behaviour:
- States and encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5.
- Reset (rst=0, asynchronous):
  - state=IDLE, pc=RESET_PC, insn=0.
  - imemReq, dmemReq, dmemWe, regWrEn and retired are all 0.
- IDLE: go to FETCH on the next edge if halt=0; otherwise stay in IDLE.
- FETCH:
  - imemReq=1 combinationally while in FETCH; imemAddr=pc.
  - On imemAck=1: latch insn<=imemData and go to DECODE.
  - Otherwise hold FETCH with imemReq kept high; the request is never dropped before its ack.
- DECODE: one cycle, then EXEC. Decoder inputs are sampled from here on.
- EXEC:
  - One cycle. At the edge leaving EXEC: pc<=brPcOut (full ADDR_WIDTH, no masking).
  - Next state is MEM if isMem=1, else WB if wbNeeded=1, else FETCH (or IDLE if halt=1).
  - On that last path (to FETCH or IDLE), retired=1 for the cycle following the edge.
- MEM:
  - dmemReq=1 and dmemWe=isStore, held until dmemAck=1.
  - On dmemAck: go to WB if wbNeeded=1 and isStore=0; otherwise to FETCH/IDLE with a retired pulse.
- WB:
  - One cycle; regWrEn=1 during WB.
  - Then FETCH (IDLE if halt=1); retired=1 in the cycle after WB.
- retired and regWrEn are registered-state decodes, exactly one cycle wide.
- Latency: minimum 4 cycles per ALU instruction (F, D, E, W) with zero-wait memory; branch/store-free non-writing instructions take 3.
- PC wrap: brPcOut arithmetic wraps modulo 2^ADDR_WIDTH. The sequencer commits the value unmodified.
- Simultaneous events:
  - halt only takes effect at instruction boundaries. An instruction in flight always completes.
  - An ack arriving in the same cycle the request first rises is accepted.
- An ack outside FETCH/MEM (spurious) is ignored.
- Reset mid-operation: returns to IDLE immediately. pc and insn reload; pending requests drop asynchronously.
- pc never changes except at the EXEC exit edge or reset.

Test Plan:
- Reset release, halt=0, imemAck tied high, ALU insn with wbNeeded=1, brPcOut=pc+4 -> states 1,2,3,5,1. pc goes 0 to 4 at the EXEC exit. regWrEn high exactly 1 cycle, retired pulses once.
- Taken branch: pc=0x40, brPcOut=0x20, isMem=0, wbNeeded=0 -> pc=0x20 after EXEC. No regWrEn. Next imemAddr=0x20 with a 3-cycle instruction.
- Load with dmemAck delayed 3 cycles -> dmemReq high 4 cycles, dmemWe=0, then WB with regWrEn=1, then FETCH.
- Store, isStore=1, wbNeeded=1 -> dmemWe=1 with dmemReq. WB is skipped, regWrEn stays 0, retired pulses after the MEM ack.
- imemAck withheld 5 cycles, halt raised during DECODE -> imemReq held 5+ cycles. The instruction completes, then state=IDLE with imemReq=0 until halt drops.
- rst asserted in MEM with dmemReq high -> dmemReq falls before the next edge, state=0, pc=RESET_PC. brPcOut=0xFFFF_FFFC+4 case commits pc=0.
